// File: rtl/core_type.sv
// Shared EX-stage types: MDU op codes and MDU sequencer states.
package core_type;
    // Bit 2 set means a divide-class op.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;
endpackage

// File: rtl/core_define.sv
// Legacy op-code defines shared by the EX-stage units (ALU and MDU).
// Values must match the enums in core_type.
`ifndef CORE_DEFINE_SV
`define CORE_DEFINE_SV
`define ALU_OP_ADD    4'd0
`define ALU_OP_SUB    4'd1
`define ALU_OP_AND    4'd2
`define ALU_OP_OR     4'd3
`define ALU_OP_XOR    4'd4
`define MDU_OP_MUL    3'd0
`define MDU_OP_MULH   3'd1
`define MDU_OP_MULHSU 3'd2
`define MDU_OP_MULHU  3'd3
`define MDU_OP_DIV    3'd4
`define MDU_OP_DIVU   3'd5
`define MDU_OP_REM    3'd6
`define MDU_OP_REMU   3'd7
`endif

// File: rtl/core_ex_mdu_div.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference if it did not borrow.
module core_ex_mdu_div #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvsr,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_dvsr};
    assign o_rem   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], ~w_diff[XLEN]};
endmodule

// File: rtl/core_ex_mdu.sv
// Iterative multiply/divide unit: XLEN shift-add or restoring-subtract steps,
// sign fixup on the last step, single request in flight.
module core_ex_mdu
    import core_type::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN + 1);

    mdu_state_t          r_state;
    mdu_op_t             r_op;
    logic [TAG_W-1:0]    r_tag;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic                r_neg_p;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;

    mdu_op_t             w_op;
    logic                w_s1, w_s2, w_n1, w_n2;
    logic [XLEN-1:0]     w_mag1, w_mag2;
    logic                w_dz, w_ovf;
    logic [XLEN-1:0]     w_byp;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_nxt, w_acc_nxt, w_prod;
    logic [XLEN-1:0]     w_rem_nxt, w_quo_nxt, w_quo, w_rem;
    logic [XLEN-1:0]     w_fin;

    assign w_op   = mdu_op_t'(in_op);
    assign w_s1   = (w_op == MDU_MUL) || (w_op == MDU_MULH) || (w_op == MDU_MULHSU) ||
                    (w_op == MDU_DIV) || (w_op == MDU_REM);
    assign w_s2   = (w_op == MDU_MUL) || (w_op == MDU_MULH) ||
                    (w_op == MDU_DIV) || (w_op == MDU_REM);
    assign w_n1   = w_s1 && in_rs1[XLEN-1];
    assign w_n2   = w_s2 && in_rs2[XLEN-1];
    assign w_mag1 = w_n1 ? -in_rs1 : in_rs1;
    assign w_mag2 = w_n2 ? -in_rs2 : in_rs2;

    // Divide corner cases resolve without iterating.
    assign w_dz   = in_op[2] && (in_rs2 == '0);
    assign w_ovf  = ((w_op == MDU_DIV) || (w_op == MDU_REM)) &&
                    (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
    always_comb begin
        w_byp = '0;
        if (w_dz)
            w_byp = (w_op == MDU_DIV || w_op == MDU_DIVU) ? '1 : in_rs1;
        else if (w_ovf)
            w_byp = (w_op == MDU_DIV) ? in_rs1 : '0;
    end

    // Multiply: accumulator = {partial hi, multiplier shifting out at bit 0}.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

    core_ex_mdu_div #(.XLEN(XLEN)) u_div (
        .i_rem  (r_acc[2*XLEN-1:XLEN]),
        .i_quo  (r_acc[XLEN-1:0]),
        .i_dvsr (r_opnd),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    assign w_acc_nxt = r_op[2] ? {w_rem_nxt, w_quo_nxt} : w_mul_nxt;
    assign w_prod    = r_neg_p ? -w_acc_nxt : w_acc_nxt;
    assign w_quo     = r_neg_p ? -w_quo_nxt : w_quo_nxt;
    assign w_rem     = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_fin = '0;
        case (r_op)
            MDU_MUL:                           w_fin = w_prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:   w_fin = w_prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                 w_fin = w_quo;
            MDU_REM, MDU_REMU:                 w_fin = w_rem;
            default:                           w_fin = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_state  <= MDU_IDLE;
            r_op     <= MDU_MUL;
            r_tag    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state  <= MDU_IDLE;
            r_cnt    <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: if (in_valid) begin
                    r_op    <= w_op;
                    r_tag   <= in_tag;
                    r_neg_p <= w_n1 ^ w_n2;
                    r_neg_r <= w_n1;
                    if (w_dz || w_ovf) begin
                        r_result <= w_byp;
                        r_state  <= MDU_DONE;
                    end else begin
                        r_opnd  <= in_op[2] ? w_mag2 : w_mag1;
                        r_acc   <= {{XLEN{1'b0}}, (in_op[2] ? w_mag1 : w_mag2)};
                        r_cnt   <= CNT_W'(XLEN);
                        r_state <= MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_fin;
                        r_state  <= MDU_DONE;
                    end
                end
                MDU_DONE: if (out_ready) r_state <= MDU_IDLE;
                default: r_state <= MDU_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == MDU_IDLE) && !flush;
    assign out_valid  = (r_state == MDU_DONE);
    assign busy       = (r_state != MDU_IDLE);
    assign out_result = r_result;
    assign out_tag    = r_tag;
endmodule

// File: tb/tb_core_ex_mdu.sv
// Directed bench for core_ex_mdu (XLEN=32): arithmetic, bypass, hold, flush, reset.
module tb_core_ex_mdu;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rest, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  in_op;
    logic [31:0] in_rs1, in_rs2, out_result;
    logic [4:0]  in_tag, out_tag;
    int          n_cmp = 0;
    int          n_err = 0;

    core_ex_mdu #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rest(rest), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Present a request for one edge; returns #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat = edges after the accept edge until out_valid is seen.
    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input int lat);
        int n;
        n = 0;
        send(op, a, b, tag);
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " result"}, out_result, exp);
        chk({name, " tag"}, out_tag, tag);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk({name, " drained"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] held_res;
        logic        seen;
        int          n;
        rest = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        #12;
        @(negedge clk) rest = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_result", out_result, 32'h0);
        chk("reset out_tag", out_tag, 5'h0);
        chk("reset busy", busy, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);

        run("mul 7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 32);
        run("mul low", OP_MUL, 32'h1234_5678, 32'h10, 5'd4, 32'h2345_6780, 32);
        run("mulh minneg^2", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 32);
        run("mulhu ones^2", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 32);
        run("mulhsu -1xff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 32);
        run("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 32);
        run("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 32);
        run("divu 100/7", OP_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 32);
        run("remu 100/7", OP_REMU, 32'd100, 32'd7, 5'd11, 32'd2, 32);
        run("div 5/0", OP_DIV, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 0);
        run("remu 5/0", OP_REMU, 32'd5, 32'd0, 5'd13, 32'd5, 0);
        run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0);
        run("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0, 0);

        // Hold the result with out_ready low while another request knocks.
        send(OP_DIVU, 32'd100, 32'd7, 5'd17);
        n = 0;
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("hold reached done", out_valid, 1'b1);
        held_res = out_result;
        chk("hold result", held_res, 32'd14);
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_MUL; in_rs1 = 32'd3; in_rs2 = 32'd3; in_tag = 5'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold stable result", out_result, 32'd14);
            chk("hold stable tag", out_tag, 5'd17);
            chk("hold in_ready low", in_ready, 1'b0);
            chk("hold out_valid", out_valid, 1'b1);
        end
        @(negedge clk); flush = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold flush out_valid", out_valid, 1'b0);
        chk("hold flush busy", busy, 1'b0);
        @(negedge clk) flush = 1'b0;
        #1 chk("hold flush in_ready", in_ready, 1'b1);

        // Flush during the fifth CALC cycle, then a fresh request.
        send(OP_DIVU, 32'd50, 32'd7, 5'd20);
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        #1 chk("flush blocks in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("flush calc busy", busy, 1'b0);
        chk("flush calc out_valid", out_valid, 1'b0);
        @(negedge clk) flush = 1'b0;
        run("divu 9/3 post-flush", OP_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 32);

        // Reset mid-CALC drops everything and emits nothing.
        send(OP_MUL, 32'd6, 32'd7, 5'd22);
        repeat (5) @(posedge clk);
        @(negedge clk) rest = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst out_result", out_result, 32'h0);
        chk("midrst out_tag", out_tag, 5'h0);
        chk("midrst busy", busy, 1'b0);
        @(negedge clk) rest = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen = seen | out_valid; end
        chk("midrst no pulse", seen, 1'b0);
        run("mul after reset", OP_MUL, 32'd6, 32'd7, 5'd23, 32'd42, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
